// File: rtl/window_gen_nxn_pkg.sv
// Shared definitions for the NxN window generator: default sizes and the
// window cell bit-position helper used by the sort/transpose blocks.
package window_gen_nxn_pkg;

  localparam int unsigned DefSize      = 3;
  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefImgWidth  = 640;

  // MSB of window cell (i,j): row 0 and column 0 sit in the most significant bits.
  function automatic int unsigned cell_msb(input int unsigned size, input int unsigned dw,
                                           input int unsigned i, input int unsigned j);
    return size * (size - i) * dw - j * dw - 1;
  endfunction

endpackage

// File: rtl/window_gen_nxn_line_buffer.sv
// One image line of delay: circular RAM read and written at the same pointer,
// so dout is the pixel accepted IMG_WIDTH enables ago.
module line_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_WIDTH  = 640
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int unsigned AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [AW-1:0] PtrLast = AW'(IMG_WIDTH - 1);

  logic [DATA_WIDTH-1:0] mem [IMG_WIDTH];
  logic [AW-1:0]         ptr_q;

  assign dout = mem[ptr_q];

  // Start position of the pointer is irrelevant: only the delay length matters.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr_q] <= din;
      ptr_q      <= (ptr_q == PtrLast) ? '0 : ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/window_gen_nxn.sv
// Streaming SIZE x SIZE window generator over a raster pixel stream; emits one
// packed window per accepted pixel once the neighbourhood is fully inside the frame.
module window_gen_nxn
  import window_gen_nxn_pkg::*;
#(
  parameter int unsigned SIZE       = DefSize,
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned IMG_WIDTH  = DefImgWidth
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_sof,
  input  logic [DATA_WIDTH-1:0]           in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [SIZE*SIZE*DATA_WIDTH-1:0] out_window
);

  localparam int unsigned CW = $clog2(IMG_WIDTH);
  localparam int unsigned RW = $clog2(SIZE);
  localparam int unsigned WW = SIZE * SIZE * DATA_WIDTH;
  localparam logic [CW-1:0] ColLast     = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] ColFirstWin = CW'(SIZE - 1);
  localparam logic [RW-1:0] RowLast     = RW'(SIZE - 1);
  localparam logic [RW-1:0] RowFill     = RW'(SIZE - 2);

  typedef enum logic [1:0] {StIdle, StFill, StRun} state_e;

  state_e                state_q;
  logic [CW-1:0]         col_q, pix_col;
  logic [RW-1:0]         row_q, pix_row;
  logic                  accept, take, produce, col_last;
  logic [DATA_WIDTH-1:0] lb_in  [SIZE-1];
  logic [DATA_WIDTH-1:0] lb_out [SIZE-1];
  logic [DATA_WIDTH-1:0] win_q  [SIZE][SIZE];
  logic [DATA_WIDTH-1:0] win_d  [SIZE][SIZE];
  logic [WW-1:0]         win_flat;

  assign in_ready = (state_q == StIdle) || !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  // In idle only a start-of-frame pixel enters the datapath.
  assign take     = accept && (in_sof || (state_q != StIdle));
  assign pix_col  = in_sof ? '0 : col_q;
  assign pix_row  = in_sof ? '0 : row_q;
  assign col_last = (pix_col == ColLast);
  assign produce  = take && !in_sof && (state_q == StRun) && (col_q >= ColFirstWin);

  for (genvar k = 0; k < SIZE - 1; k++) begin : g_lb
    if (k == 0) begin : g_head
      assign lb_in[k] = in_data;
    end else begin : g_chain
      assign lb_in[k] = lb_out[k-1];
    end
    line_buffer #(
      .DATA_WIDTH(DATA_WIDTH),
      .IMG_WIDTH (IMG_WIDTH)
    ) u_lb (
      .clk (clk),
      .en  (take),
      .din (lb_in[k]),
      .dout(lb_out[k])
    );
  end

  // Shift left one column; new right column is oldest line at the top.
  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      for (int j = 0; j < SIZE - 1; j++) begin
        win_d[i][j] = win_q[i][j+1];
      end
    end
    for (int i = 0; i < SIZE - 1; i++) begin
      win_d[i][SIZE-1] = lb_out[SIZE-2-i];
    end
    win_d[SIZE-1][SIZE-1] = in_data;
  end

  for (genvar i = 0; i < SIZE; i++) begin : g_row
    for (genvar j = 0; j < SIZE; j++) begin : g_col
      localparam int unsigned Msb = cell_msb(SIZE, DATA_WIDTH, i, j);
      assign win_flat[Msb -: DATA_WIDTH] = win_d[i][j];
    end
  end

  always_ff @(posedge clk) begin
    if (take) begin
      win_q <= win_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      col_q      <= '0;
      row_q      <= '0;
      out_valid  <= 1'b0;
      out_window <= '0;
    end else begin
      if (produce) begin
        out_valid  <= 1'b1;
        out_window <= win_flat;
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end
      if (take) begin
        col_q <= col_last ? '0 : pix_col + 1'b1;
        row_q <= (col_last && (pix_row != RowLast)) ? pix_row + 1'b1 : pix_row;
        if (in_sof) begin
          state_q <= StFill;
        end else if ((state_q == StFill) && col_last && (row_q == RowFill)) begin
          state_q <= StRun;
        end
      end
    end
  end

endmodule

// File: tb/tb_window_gen_nxn.sv
// Scoreboard bench for window_gen_nxn (SIZE=3, 8-bit pixels, 4-pixel lines,
// pixel value = base + row*16 + col).
module tb_window_gen_nxn;

  localparam int unsigned SIZE = 3;
  localparam int unsigned DW   = 8;
  localparam int unsigned IW   = 4;
  localparam int unsigned WW   = SIZE * SIZE * DW;
  localparam logic [WW-1:0] FirstWin = 72'h00_01_02_10_11_12_20_21_22;
  localparam logic [WW-1:0] LastWin  = 72'h11_12_13_21_22_23_31_32_33;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_sof = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [WW-1:0] out_window;

  int            checks = 0;
  int            failures = 0;
  int            popped = 0;
  int            mark = 0;
  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] first_got = '0;
  logic [WW-1:0] last_got = '0;
  logic [WW-1:0] held_win = '0;
  bit            hold_prev = 1'b0;
  bit            rnd_on = 1'b0;

  window_gen_nxn #(
    .SIZE      (SIZE),
    .DATA_WIDTH(DW),
    .IMG_WIDTH (IW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_window(out_window)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [WW-1:0] exp_win(input int base, input int r, input int c);
    logic [WW-1:0] w;
    logic [DW-1:0] px;
    w = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        px = 8'(base + (r - 2 + i) * 16 + (c - 2 + j));
        w  = {w[WW-DW-1:0], px};
      end
    end
    return w;
  endfunction

  // Monitor: pops on every output transfer, checks hold stability under backpressure.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_window", out_window, held_win);
      end
      if (out_valid && !out_ready) begin
        check("bp_in_ready", in_ready, 0);
        hold_prev = 1'b1;
        held_win  = out_window;
      end else begin
        hold_prev = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (popped == mark) first_got = out_window;
        last_got = out_window;
        popped++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_window: got %0h expected none", out_window);
        end else begin
          check("window", out_window, exp_q.pop_front());
        end
      end
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic sof);
    int   n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      n++;
    end
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got no accept expected accept of %0h", d);
    end
  endtask

  task automatic send_frame(input int base, input int npix, input bit chk_valid, input bit gaps);
    int r;
    int c;
    bit win;
    for (int p = 0; p < npix; p++) begin
      r   = p / IW;
      c   = p % IW;
      win = (r >= 2) && (c >= 2);
      if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      if (win) exp_q.push_back(exp_win(base, r, c));
      send(8'(base + r * 16 + c), p == 0);
      if (chk_valid) check("valid_latency", out_valid, win);
    end
  endtask

  task automatic drain(input int expect_n, input logic [WW-1:0] f_exp, input logic [WW-1:0] l_exp);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
    check("window_count", popped - mark, expect_n);
    check("first_window", first_got, f_exp);
    check("last_window", last_got, l_exp);
    mark = popped;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_window", out_window, 0);
    check("reset_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Plain frame
    send_frame(0, 16, 1, 0);
    drain(4, FirstWin, LastWin);

    // Pixels before sof are dropped
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++) begin
      check("discard_ready", in_ready, 1);
      send(8'(8'h55 + k), 1'b0);
      check("discard_valid", out_valid, 0);
    end
    send_frame(0, 16, 1, 0);
    drain(4, FirstWin, LastWin);

    // Backpressure on the first window
    out_ready = 1'b0;
    fork
      send_frame(0, 16, 0, 0);
      begin
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        check("bp_pending", out_valid, 1);
        repeat (5) begin
          @(negedge clk);
          check("bp_window", out_window, FirstWin);
          check("bp_stall", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain(4, FirstWin, LastWin);

    // sof at row 2, col 1 of frame A
    send_frame('h40, 9, 1, 0);
    send_frame('h80, 16, 1, 0);
    drain(4, exp_win('h80, 2, 2), exp_win('h80, 3, 3));

    // Reset with a window pending
    send_frame(0, 11, 1, 0);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", out_valid, 0);
    check("rst_async_window", out_window, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_lost_windows", exp_q.size(), 1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mark = popped;
    send_frame(0, 16, 1, 0);
    drain(4, FirstWin, LastWin);

    // Random valid/ready over three frames
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        send_frame(0, 16, 0, 1);
        send_frame('h50, 20, 0, 1);
        send_frame('hA0, 16, 0, 1);
        rnd_on = 1'b0;
      end
    join
    out_ready = 1'b1;
    drain(14, FirstWin, exp_win('hA0, 3, 3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
